// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encodings, opcode values and widths.
// Optional IDCODE support is enabled elsewhere with the TAP_IDCODE_EN macro.
package tap_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  // Opcode values; the controller sizes them to IRLEN (EXTEST is all 0, BYPASS all 1).
  localparam int OPC_EXTEST = 0;
  localparam int OPC_SAMPLE = 1;
  localparam int OPC_IDCODE = 2;

endpackage

// File: rtl/tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine: state register plus next-state logic.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       CK,
  input  logic       RST,
  input  logic       TMS,
  output tap_state_e State
);

  tap_state_e next_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CK) begin
    if (RST) State <= TLR;
    else     State <= next_state;
  end

  // NOTE: next_state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    next_state = State;
    case (State)
      TLR:      next_state = TMS ? TLR    : RTI;
      RTI:      next_state = TMS ? SEL_DR : RTI;
      SEL_DR:   next_state = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   next_state = TMS ? EX1_DR : SH_DR;
      SH_DR:    next_state = TMS ? EX1_DR : SH_DR;
      EX1_DR:   next_state = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next_state = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   next_state = TMS ? UPD_DR : SH_DR;
      UPD_DR:   next_state = TMS ? SEL_DR : RTI;
      SEL_IR:   next_state = TMS ? TLR    : CAP_IR;
      CAP_IR:   next_state = TMS ? EX1_IR : SH_IR;
      SH_IR:    next_state = TMS ? EX1_IR : SH_IR;
      EX1_IR:   next_state = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next_state = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   next_state = TMS ? UPD_IR : SH_IR;
      UPD_IR:   next_state = TMS ? SEL_DR : RTI;
      default:  next_state = TLR;
    endcase
  end

endmodule

// File: rtl/tap_controller.sv
// TAP controller driving the boundary-scan register control pins (ShiftDR/ClockDR/UpdateDR/Mode).
// Define TAP_IDCODE_EN to add the 32-bit IDCODE data register and opcode.
module tap_controller
  import tap_pkg::*;
#(
  parameter int IRLEN  = 4,
  parameter int BSRLEN = 8
`ifdef TAP_IDCODE_EN
  ,
  parameter logic [31:0] IDCODE_VAL = 32'h0000_1001
`endif
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             TMS,
  input  logic             TDI,
  input  logic             BSR_SO,
  output logic             SI,
  output logic             TDO,
  output logic             TDO_EN,
  output logic             ShiftDR,
  output logic             ClockDR,
  output logic             UpdateDR,
  output logic             Mode,
  output logic [IRLEN-1:0] IR,
  output logic [3:0]       State
);

  localparam logic [IRLEN-1:0] OP_EXTEST = IRLEN'(OPC_EXTEST);
  localparam logic [IRLEN-1:0] OP_SAMPLE = IRLEN'(OPC_SAMPLE);
  localparam logic [IRLEN-1:0] OP_BYPASS = '1;
`ifdef TAP_IDCODE_EN
  localparam logic [IRLEN-1:0] OP_IDCODE = IRLEN'(OPC_IDCODE);
  localparam logic [IRLEN-1:0] IR_RESET  = OP_IDCODE;
`else
  localparam logic [IRLEN-1:0] IR_RESET  = OP_BYPASS;
`endif

  if (IRLEN < 2 || BSRLEN < 1) begin : g_bad_params
    $error("tap_controller: IRLEN must be >= 2 and BSRLEN >= 1");
  end

  tap_state_e       state;
  logic [IRLEN-1:0] ir_q;
  logic [IRLEN-1:0] irs_q;
  logic             bypass_q;
  logic             bsr_sel;
  logic             id_sel;
  logic             id_tdo;
  logic             tlr_load;

  tap_fsm u_fsm (
    .CK    (CK),
    .RST   (RST),
    .TMS   (TMS),
    .State (state)
  );

  assign bsr_sel  = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE);
  // SEL_IR with TMS=1 is the only way into TLR, so this covers both entering and staying there.
  assign tlr_load = (state == TLR) || (state == SEL_IR && TMS);

  always_ff @(posedge CK) begin
    if (RST) begin
      ir_q     <= IR_RESET;
      irs_q    <= OP_BYPASS;
      bypass_q <= 1'b0;
    end else begin
      if (tlr_load) begin
        ir_q  <= IR_RESET;
        irs_q <= OP_BYPASS;
      end else begin
        case (state)
          CAP_IR:  irs_q <= OP_SAMPLE;
          SH_IR:   irs_q <= {TDI, irs_q[IRLEN-1:1]};
          UPD_IR:  ir_q  <= irs_q;
          default: ;
        endcase
      end
      if (state == CAP_DR)
        bypass_q <= 1'b0;
      else if (state == SH_DR && !bsr_sel && !id_sel)
        bypass_q <= TDI;
    end
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] id_q;

  if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
    $error("tap_controller: IDCODE_VAL bit 0 must be 1");
  end

  assign id_sel = (ir_q == OP_IDCODE);
  assign id_tdo = id_q[0];

  always_ff @(posedge CK) begin
    if (RST)
      id_q <= IDCODE_VAL;
    else if (id_sel && state == CAP_DR)
      id_q <= IDCODE_VAL;
    else if (id_sel && state == SH_DR)
      id_q <= {TDI, id_q[31:1]};
  end
`else
  assign id_sel = 1'b0;
  assign id_tdo = 1'b0;
`endif

  always_comb begin
    TDO = 1'b0;
    case (state)
      SH_IR: TDO = irs_q[0];
      SH_DR: begin
        if (bsr_sel)     TDO = BSR_SO;
        else if (id_sel) TDO = id_tdo;
        else             TDO = bypass_q;
      end
      default: ;
    endcase
  end

  assign SI       = TDI;
  assign TDO_EN   = (state == SH_IR) || (state == SH_DR);
  assign ShiftDR  = (state == SH_DR);
  assign ClockDR  = bsr_sel && (state == CAP_DR || state == SH_DR);
  assign UpdateDR = bsr_sel && (state == UPD_DR);
  assign Mode     = (ir_q == OP_EXTEST);
  assign IR       = ir_q;
  assign State    = state;

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: vector table for the IR load, hand sequences for DR scans and resets.
module tb_tap_controller;
  import tap_pkg::*;

  localparam int IRLEN  = 4;
  localparam int BSRLEN = 8;
`ifdef TAP_IDCODE_EN
  localparam logic [3:0] IR_RST = 4'b0010;
`else
  localparam logic [3:0] IR_RST = 4'b1111;
`endif

  logic       CK = 1'b0;
  logic       RST, TMS, TDI, BSR_SO;
  logic       SI, TDO, TDO_EN, ShiftDR, ClockDR, UpdateDR, Mode;
  logic [3:0] IR, State;

  int checks   = 0;
  int failures = 0;
  int n_clk, n_sh, n_upd;

  typedef struct packed {
    logic       tms;
    logic       tdi;
    logic [3:0] st;
    logic       tdo;
    logic       tdo_en;
    logic [3:0] ir;
    logic       mode;
  } vec_t;

  vec_t vecs[11];
  vec_t sb[$];
  logic bq[$];

  tap_controller #(.IRLEN(IRLEN), .BSRLEN(BSRLEN)) dut (
    .CK       (CK),
    .RST      (RST),
    .TMS      (TMS),
    .TDI      (TDI),
    .BSR_SO   (BSR_SO),
    .SI       (SI),
    .TDO      (TDO),
    .TDO_EN   (TDO_EN),
    .ShiftDR  (ShiftDR),
    .ClockDR  (ClockDR),
    .UpdateDR (UpdateDR),
    .Mode     (Mode),
    .IR       (IR),
    .State    (State)
  );

  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle 1 ns before any sampling.
  task automatic step(input logic tms, input logic tdi);
    TMS    = tms;
    TDI    = tdi;
    BSR_SO = 1'($urandom_range(0, 1));
    @(posedge CK);
    #1;
  endtask

  task automatic tally();
    n_clk += int'(ClockDR);
    n_sh  += int'(ShiftDR);
    n_upd += int'(UpdateDR);
  endtask

  // From RTI: scan value v into the IR, return to RTI.
  task automatic load_ir(input logic [3:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < IRLEN; i++) step(i == IRLEN - 1, v[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("load_ir_state", State, RTI);
    check("load_ir_value", IR, v);
  endtask

  initial begin
    logic [8:0] data;
    logic       exp_bit;
    vec_t       e;

    RST = 1'b1; TMS = 1'b0; TDI = 1'b0; BSR_SO = 1'b0;

    // Reset: one edge with RST=1, TMS=0.
    @(posedge CK);
    #1;
    check("rst_state",    State,    4'hF);
    check("rst_ir",       IR,       IR_RST);
    check("rst_mode",     Mode,     1'b0);
    check("rst_clockdr",  ClockDR,  1'b0);
    check("rst_updatedr", UpdateDR, 1'b0);
    check("rst_shiftdr",  ShiftDR,  1'b0);
    check("rst_tdo",      TDO,      1'b0);
    check("rst_tdo_en",   TDO_EN,   1'b0);
    RST = 1'b0;

    // IR load of EXTEST from TLR, one record per edge.
    vecs[0]  = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, IR_RST,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h7, 1'b0, 1'b0, IR_RST,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'h4, 1'b0, 1'b0, IR_RST,  1'b0};
    vecs[3]  = '{1'b0, 1'b0, 4'hE, 1'b0, 1'b0, IR_RST,  1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'hA, 1'b1, 1'b1, IR_RST,  1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, IR_RST,  1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, IR_RST,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 4'hA, 1'b0, 1'b1, IR_RST,  1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'h9, 1'b0, 1'b0, IR_RST,  1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'hD, 1'b0, 1'b0, IR_RST,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 4'b0000, 1'b1};
    for (int i = 0; i < 11; i++) begin
      sb.push_back(vecs[i]);
      step(vecs[i].tms, vecs[i].tdi);
      e = sb.pop_front();
      check($sformatf("vec%0d_state", i),  State,  e.st);
      check($sformatf("vec%0d_tdo", i),    TDO,    e.tdo);
      check($sformatf("vec%0d_tdo_en", i), TDO_EN, e.tdo_en);
      check($sformatf("vec%0d_ir", i),     IR,     e.ir);
      check($sformatf("vec%0d_mode", i),   Mode,   e.mode);
    end
    check("si_follows_tdi", SI, TDI);

    // SAMPLE DR scan over the 8-cell BSR.
    load_ir(4'b0001);
    n_clk = 0; n_sh = 0; n_upd = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("sample_capdr", State, CAP_DR);
    tally();
    step(1'b0, 1'b0);
    for (int k = 0; k < BSRLEN; k++) begin
      check("sample_shdr_state", State, SH_DR);
      check("sample_tdo_bsr_so", TDO, BSR_SO);
      check("sample_mode", Mode, 1'b0);
      tally();
      step(k == BSRLEN - 1, 1'($urandom_range(0, 1)));
    end
    tally();
    step(1'b1, 1'b0);
    check("sample_upddr_pulse", UpdateDR, 1'b1);
    tally();
    step(1'b0, 1'b0);
    tally();
    check("sample_clockdr_cycles",  n_clk, BSRLEN + 1);
    check("sample_shiftdr_cycles",  n_sh,  BSRLEN);
    check("sample_updatedr_cycles", n_upd, 1);

    // BYPASS: A5 LSB first plus one trailing bit; TDO lags TDI by one cycle.
    load_ir(4'b1111);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    data = 9'h0A5;
    bq.push_back(1'b0);
    for (int k = 0; k < 9; k++) begin
      exp_bit = bq.pop_front();
      check($sformatf("bypass_tdo%0d", k), TDO, exp_bit);
      check("bypass_clockdr", ClockDR, 1'b0);
      bq.push_back(data[k]);
      step(k == 8, data[k]);
    end
    step(1'b1, 1'b0);
    check("bypass_upddr_state", State, UPD_DR);
    check("bypass_updatedr", UpdateDR, 1'b0);
    step(1'b0, 1'b0);

    // TMS reset from ShDR with an undefined opcode loaded.
    load_ir(4'b0101);
    check("undef_not_bsr", ClockDR | Mode, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("tmsrst_start", State, SH_DR);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0);
      check("tmsrst_updatedr", UpdateDR, 1'b0);
    end
    check("tmsrst_state", State, 4'hF);
    check("tmsrst_ir", IR, IR_RST);

    // Mid-scan RST during the 3rd ShDR cycle of a SAMPLE scan.
    step(1'b0, 1'b0);
    load_ir(4'b0001);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("midrst_in_shdr", State, SH_DR);
    RST = 1'b1;
    step(1'b1, 1'b1);
    RST = 1'b0;
    check("midrst_state", State, 4'hF);
    check("midrst_ir", IR, IR_RST);
    check("midrst_shiftdr", ShiftDR, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step((k == 1) || (k == 3) || (k == 4), 1'b0);
      check("midrst_updatedr", UpdateDR, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
